// File: rtl/packet_check_pkg.sv
// Shared types and helpers for the loopback packet checker.
package packet_check_pkg;
  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int POP_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DRAIN, ST_DONE} state_e;

  // Per-beat information that travels alongside the popcount pipeline.
  typedef struct packed {
    logic        keep_mm;
    logic        last_mm;
    logic [63:0] pkt;
  } side_t;

  // Adds without wrapping past maxv (the caller's all-ones counter value).
  function automatic logic [63:0] sat_add(input logic [63:0] cur, input logic [63:0] inc,
                                          input logic [63:0] maxv);
    if (inc > maxv - cur) return maxv;
    return cur + inc;
  endfunction
endpackage

// File: rtl/packet_check_popcount.sv
// Two-stage registered popcount: 64-bit chunk sums, then a sum of the partials.
module popcount_pipe #(
  parameter int  DATA_W = packet_check_pkg::DATA_W,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [CNT_W-1:0]  out_cnt
);
  localparam int NCH = (DATA_W + 63) / 64;

  logic [NCH*64-1:0]    pad;
  logic [NCH-1:0][6:0]  part_d, part_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [1:0]           vld_pipe_q;

  always_comb begin
    pad = '0;
    pad[DATA_W-1:0] = in_data;
    for (int c = 0; c < NCH; c++) begin
      part_d[c] = '0;
      for (int b = 0; b < 64; b++) part_d[c] = part_d[c] + 7'(pad[c*64+b]);
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int c = 0; c < NCH; c++) cnt_d = cnt_d + CNT_W'(part_q[c]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      part_q     <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      part_q     <= part_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[0], in_vld};
    end
  end

  assign out_vld = vld_pipe_q[1];
  assign out_cnt = cnt_q;
endmodule

// File: rtl/packet_check.sv
// Loopback checker: joins the returned stream with the reference stream and counts errors.
module packet_check #(
  parameter int DATA_W         = packet_check_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         PACKET_COUNT,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [63:0]         packets_rcvd,
  output logic [ERR_W-1:0]    bad_beats,
  output logic [ERR_W-1:0]    bit_errors,
  output logic [ERR_W-1:0]    framing_errors,
  output logic [63:0]         first_err_packet,
  input  logic [DATA_W-1:0]   AXIS_IN_TDATA,
  input  logic [DATA_W/8-1:0] AXIS_IN_TKEEP,
  input  logic                AXIS_IN_TLAST,
  input  logic                AXIS_IN_TVALID,
  output logic                AXIS_IN_TREADY,
  input  logic [DATA_W-1:0]   AXIS_EXP_TDATA,
  input  logic [DATA_W/8-1:0] AXIS_EXP_TKEEP,
  input  logic                AXIS_EXP_TLAST,
  input  logic                AXIS_EXP_TVALID,
  output logic                AXIS_EXP_TREADY
);
  import packet_check_pkg::*;

  localparam int KW = DATA_W / 8;
  localparam int CW = $clog2(DATA_W) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [63:0] ERR_MAX = 64'({ERR_W{1'b1}});

  state_e            state_d, state_q;
  logic [63:0]       cnt_d, cnt_q, pkts_d, pkts_q, first_d, first_q;
  logic [TW-1:0]     tmo_d, tmo_q;
  logic [1:0]        drain_d, drain_q;
  logic              timeout_d, timeout_q, clr, in_check, acc, bad_beat;
  logic [ERR_W-1:0]  bad_d, bad_q, bit_d, bit_q, frm_d, frm_q;
  logic [DATA_W-1:0] kx_d, kx_q;
  logic              s1_vld_q, pc_vld;
  logic [CW-1:0]     pc_cnt;
  side_t             side_d;
  side_t [2:0]       side_q;

  // Join: neither stream advances unless both present a beat.
  assign in_check        = state_q == ST_CHECK;
  assign AXIS_IN_TREADY  = in_check & AXIS_EXP_TVALID;
  assign AXIS_EXP_TREADY = in_check & AXIS_IN_TVALID;
  assign acc             = in_check & AXIS_IN_TVALID & AXIS_EXP_TVALID;

  always_comb begin
    kx_d = '0;
    for (int i = 0; i < KW; i++)
      if (AXIS_EXP_TKEEP[i]) kx_d[i*8 +: 8] = AXIS_IN_TDATA[i*8 +: 8] ^ AXIS_EXP_TDATA[i*8 +: 8];
    side_d.keep_mm = AXIS_IN_TKEEP != AXIS_EXP_TKEEP;
    side_d.last_mm = AXIS_IN_TLAST != AXIS_EXP_TLAST;
    side_d.pkt     = pkts_q + 64'd1;
  end

  popcount_pipe #(.DATA_W(DATA_W)) u_pop (
    .clk(clk), .reset(reset), .in_vld(s1_vld_q), .in_data(kx_q),
    .out_vld(pc_vld), .out_cnt(pc_cnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    pkts_d    = pkts_q;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        clr       = 1'b1;
        cnt_d     = PACKET_COUNT;
        tmo_d     = TW'(TIMEOUT_CYCLES);
        timeout_d = 1'b0;
        pkts_d    = '0;
        state_d   = (PACKET_COUNT == '0) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        if (acc) begin
          tmo_d = TW'(TIMEOUT_CYCLES);
          if (AXIS_EXP_TLAST) begin
            pkts_d = pkts_q + 64'd1;
            if (pkts_d == cnt_q) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end
        end else if (tmo_q <= TW'(1)) begin
          tmo_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
          drain_d   = '0;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error accounting from the pipeline tail; a start clears everything.
  always_comb begin
    bad_beat = pc_vld & ((pc_cnt != '0) | side_q[2].keep_mm | side_q[2].last_mm);
    bit_d    = bit_q;
    bad_d    = bad_q;
    frm_d    = frm_q;
    first_d  = first_q;
    if (pc_vld) begin
      bit_d = ERR_W'(sat_add(64'(bit_q), 64'(pc_cnt), ERR_MAX));
      if (bad_beat) bad_d = ERR_W'(sat_add(64'(bad_q), 64'd1, ERR_MAX));
      if (side_q[2].last_mm) frm_d = ERR_W'(sat_add(64'(frm_q), 64'd1, ERR_MAX));
      if (bad_beat && first_q == '0) first_d = side_q[2].pkt;
    end
    if (clr) begin
      bit_d   = '0;
      bad_d   = '0;
      frm_d   = '0;
      first_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
      pkts_q    <= '0;
      bad_q     <= '0;
      bit_q     <= '0;
      frm_q     <= '0;
      first_q   <= '0;
      kx_q      <= '0;
      s1_vld_q  <= 1'b0;
      side_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
      pkts_q    <= pkts_d;
      bad_q     <= bad_d;
      bit_q     <= bit_d;
      frm_q     <= frm_d;
      first_q   <= first_d;
      kx_q      <= kx_d;
      s1_vld_q  <= acc;
      side_q    <= {side_q[1:0], side_d};
    end
  end

  assign busy             = (state_q == ST_CHECK) | (state_q == ST_DRAIN);
  assign done             = state_q == ST_DONE;
  assign timeout          = timeout_q;
  assign pass             = done & ~timeout_q & (bad_q == '0) & (frm_q == '0);
  assign packets_rcvd     = pkts_q;
  assign bad_beats        = bad_q;
  assign bit_errors       = bit_q;
  assign framing_errors   = frm_q;
  assign first_err_packet = first_q;
endmodule

// File: tb/tb_packet_check.sv
// Randomized scoreboard bench for packet_check with a packet-level reference model.
module tb_packet_check;
  localparam int DW = 512, KW = 64, EW = 6, TMO = 50;
  localparam logic [63:0] EMAX = 64'(2**EW - 1);

  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  typedef struct {
    logic [63:0] pk, bad, bits, frm, first;
    logic pass, tmo;
    int acc, lat;
  } res_t;

  logic clk = 0, reset = 1, start = 0;
  logic [63:0] PACKET_COUNT = '0;
  logic busy, done, pass, timeout;
  logic [63:0] packets_rcvd, first_err_packet;
  logic [EW-1:0] bad_beats, bit_errors, framing_errors;
  logic [DW-1:0] AXIS_IN_TDATA = '0, AXIS_EXP_TDATA = '0;
  logic [KW-1:0] AXIS_IN_TKEEP = '0, AXIS_EXP_TKEEP = '0;
  logic AXIS_IN_TLAST = 0, AXIS_IN_TVALID = 0, AXIS_IN_TREADY;
  logic AXIS_EXP_TLAST = 0, AXIS_EXP_TVALID = 0, AXIS_EXP_TREADY;

  packet_check #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .PACKET_COUNT(PACKET_COUNT), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .packets_rcvd(packets_rcvd), .bad_beats(bad_beats), .bit_errors(bit_errors),
    .framing_errors(framing_errors), .first_err_packet(first_err_packet),
    .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TKEEP(AXIS_IN_TKEEP), .AXIS_IN_TLAST(AXIS_IN_TLAST),
    .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
    .AXIS_EXP_TDATA(AXIS_EXP_TDATA), .AXIS_EXP_TKEEP(AXIS_EXP_TKEEP), .AXIS_EXP_TLAST(AXIS_EXP_TLAST),
    .AXIS_EXP_TVALID(AXIS_EXP_TVALID), .AXIS_EXP_TREADY(AXIS_EXP_TREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, gap_pct = 0;
  beat_t sin[$], sexp[$], drv_in[$], drv_exp[$];
  res_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] smin(input logic [63:0] a, input logic [63:0] b);
    return (a < b) ? a : b;
  endfunction

  // Reference: walk beat pairs in order, packets delimited by the expected stream.
  function automatic res_t model(input logic [63:0] cnt);
    res_t r;
    logic [DW-1:0] x;
    logic [63:0] pc, idx;
    bit fin, b;
    int n;
    r = '{default: 0};
    idx = 1;
    fin = (cnt == 0);
    n = (sin.size() < sexp.size()) ? sin.size() : sexp.size();
    for (int i = 0; i < n && !fin; i++) begin
      x = '0;
      for (int j = 0; j < KW; j++)
        if (sexp[i].k[j]) x[j*8 +: 8] = sin[i].d[j*8 +: 8] ^ sexp[i].d[j*8 +: 8];
      pc = 64'($countones(x));
      b = (pc != 0) || (sin[i].k != sexp[i].k) || (sin[i].l != sexp[i].l);
      r.bits = smin(r.bits + pc, EMAX);
      if (b) begin
        r.bad = smin(r.bad + 1, EMAX);
        if (r.first == 0) r.first = idx;
      end
      if (sin[i].l != sexp[i].l) r.frm = smin(r.frm + 1, EMAX);
      r.acc++;
      if (sexp[i].l) begin
        r.pk++;
        if (r.pk == cnt) fin = 1;
        idx++;
      end
    end
    r.tmo  = !fin;
    r.pass = !r.tmo && r.bad == 0 && r.frm == 0;
    r.lat  = r.tmo ? 4 + TMO : 4;
    return r;
  endfunction

  task automatic build(input int npk, input int bpp, input bit partial);
    beat_t e, x;
    sin.delete(); sexp.delete();
    for (int p = 0; p < npk; p++)
      for (int b = 0; b < bpp; b++) begin
        for (int w = 0; w < DW/32; w++) e.d[w*32 +: 32] = $urandom;
        e.k = '1;
        e.l = (b == bpp - 1);
        if (partial && e.l) e.k = {32'($urandom), 32'($urandom)} | 64'd1;
        x = e;
        for (int j = 0; j < KW; j++) if (!e.k[j]) x.d[j*8 +: 8] = 8'($urandom);
        sexp.push_back(e);
        sin.push_back(x);
      end
  endtask

  task automatic flip(input int i, input int bt);
    beat_t x;
    x = sin[i]; x.d[bt] = ~x.d[bt]; sin[i] = x;
  endtask

  task automatic set_last(input int i, input logic v);
    beat_t x;
    x = sin[i]; x.l = v; sin[i] = x;
  endtask

  task automatic run(input logic [63:0] cnt, input int gap);
    sb.push_back(model(cnt));
    gap_pct = gap;
    drv_in = sin; drv_exp = sexp;
    @(negedge clk); PACKET_COUNT = cnt; start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    chk("run_completed", 64'(sb.size()), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    drv_in.delete(); drv_exp.delete();
  endtask

  // Driver: AXIS sources with random gaps; a presented beat is held until taken.
  initial begin : driver
    bit iv = 0, ev = 0, fi, fe;
    forever begin
      @(negedge clk);
      iv = iv ? (drv_in.size() > 0) : (drv_in.size() > 0 && $urandom_range(99) >= gap_pct);
      ev = ev ? (drv_exp.size() > 0) : (drv_exp.size() > 0 && $urandom_range(99) >= gap_pct);
      AXIS_IN_TVALID = iv;
      AXIS_EXP_TVALID = ev;
      if (iv) {AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST} = drv_in[0];
      if (ev) {AXIS_EXP_TDATA, AXIS_EXP_TKEEP, AXIS_EXP_TLAST} = drv_exp[0];
      #1;
      fi = iv && AXIS_IN_TREADY;
      fe = ev && AXIS_EXP_TREADY;
      @(posedge clk);
      if (fi) begin if (drv_in.size() > 0) void'(drv_in.pop_front()); iv = 0; end
      if (fe) begin if (drv_exp.size() > 0) void'(drv_exp.pop_front()); ev = 0; end
    end
  end

  // Monitor: handshake rules every cycle, result check on each rising done.
  initial begin : monitor
    int cyc = 0, last_acc = 0, nacc = 0, viol = 0;
    bit pd = 0, ai, ae;
    res_t e;
    forever begin
      @(negedge clk); #2; cyc++;
      if (reset) begin
        nacc = 0; viol = 0; pd = 0;
      end else begin
        ai = AXIS_IN_TVALID && AXIS_IN_TREADY;
        ae = AXIS_EXP_TVALID && AXIS_EXP_TREADY;
        if (AXIS_IN_TREADY && !AXIS_EXP_TVALID) viol++;
        if (AXIS_EXP_TREADY && !AXIS_IN_TVALID) viol++;
        if ((AXIS_IN_TREADY || AXIS_EXP_TREADY) && !busy) viol++;
        if (ai != ae) viol++;
        if (ai) begin nacc++; last_acc = cyc; end
        if (done && !pd) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("packets_rcvd", packets_rcvd, e.pk);
            chk("bad_beats", 64'(bad_beats), e.bad);
            chk("bit_errors", 64'(bit_errors), e.bits);
            chk("framing_errors", 64'(framing_errors), e.frm);
            chk("first_err_packet", first_err_packet, e.first);
            chk("pass", 64'(pass), 64'(e.pass));
            chk("timeout", 64'(timeout), 64'(e.tmo));
            chk("busy_at_done", 64'(busy), 0);
            chk("accepted_beats", 64'(nacc), 64'(e.acc));
            chk("join_violations", 64'(viol), 0);
            if (e.acc > 0) chk("done_latency", 64'(cyc - last_acc), 64'(e.lat));
          end
          nacc = 0; viol = 0;
        end
        pd = done;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pass_timeout"}, 64'({pass, timeout}), 0);
    chk({tag, "_packets"}, packets_rcvd, 0);
    chk({tag, "_errs"}, 64'({bad_beats, bit_errors, framing_errors}), 0);
    chk({tag, "_first"}, first_err_packet, 0);
    chk({tag, "_treadys"}, 64'({AXIS_IN_TREADY, AXIS_EXP_TREADY}), 0);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;

    build(4, 8, 0); run(4, 0);                                    // clean
    build(4, 8, 0); flip(20, 300); flip(24, 0); flip(24, 511); run(4, 0);
    build(4, 8, 0); set_last(14, 1); set_last(15, 0); run(4, 0);  // early IN TLAST
    build(4, 8, 0); run(4, 50);                                   // gappy valids
    build(4, 16, 0);                                              // IN stops mid packet 2
    while (sin.size() > 26) void'(sin.pop_back());
    run(4, 0);
    build(3, 6, 1); flip(7, 9);                                   // partial keep, garbage unkept
    begin beat_t x; x = sin[4]; x.k[3] = ~x.k[3]; sin[4] = x; end
    run(3, 30);
    build(1, 80, 0);                                              // saturation
    for (int i = 0; i < 80; i++) flip(i, $urandom_range(DW - 1));
    run(1, 20);

    // Reset mid-run, then a zero-length run.
    build(4, 8, 0);
    gap_pct = 0; drv_in = sin; drv_exp = sexp;
    @(negedge clk); PACKET_COUNT = 4; start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    #3 reset = 1;
    #1 chk_zero("async_reset");
    drv_in.delete(); drv_exp.delete();
    @(negedge clk); #3 reset = 0;
    sin.delete(); sexp.delete();
    run(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
